// File: rtl/op_sequencer.sv
// op_sequencer: IDLE/EXEC/DONE sequencer driving an external operation unit.
// Define OP_SEQUENCER_FLAGS_EN to build the zero/negative/overflow flag registers.
module op_sequencer #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [1:0]       opcode,
    input  logic [width-1:0] a_in,
    input  logic [width-1:0] b_in,
    output logic [width-1:0] Ain,
    output logic [width-1:0] Bin,
    output logic             addSubVals,
    output logic             andVals,
    output logic             notBVal,
    output logic             sub,
    input  logic [width-1:0] computedValue,
    input  logic             overflow,
    output logic [width-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    state_t           r_state;
    logic [width-1:0] r_a;
    logic [width-1:0] r_b;
    logic [width-1:0] r_result;
    logic             r_instr_ready;
    logic             r_result_valid;
    logic             r_add_sub;
    logic             r_sub;
    logic             r_and;
    logic             r_not;

    // Controls are decoded at the accepting edge so they are high for exactly the EXEC cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_instr_ready  <= 1'b1;
            r_result_valid <= 1'b0;
            r_a            <= '0;
            r_b            <= '0;
            r_result       <= '0;
            r_add_sub      <= 1'b0;
            r_sub          <= 1'b0;
            r_and          <= 1'b0;
            r_not          <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_a           <= a_in;
                        r_b           <= b_in;
                        r_state       <= S_EXEC;
                        r_instr_ready <= 1'b0;
                        r_add_sub     <= 1'b0;
                        r_sub         <= 1'b0;
                        r_and         <= 1'b0;
                        r_not         <= 1'b0;
                        unique case (opcode)
                            OP_ADD: r_add_sub <= 1'b1;
                            OP_SUB: begin
                                r_add_sub <= 1'b1;
                                r_sub     <= 1'b1;
                            end
                            OP_AND: r_and <= 1'b1;
                            OP_NOT: r_not <= 1'b1;
                            default: r_add_sub <= 1'b0;
                        endcase
                    end
                end
                S_EXEC: begin
                    r_result       <= computedValue;
                    r_result_valid <= 1'b1;
                    r_add_sub      <= 1'b0;
                    r_sub          <= 1'b0;
                    r_and          <= 1'b0;
                    r_not          <= 1'b0;
                    r_state        <= S_DONE;
                end
                S_DONE: begin
                    if (result_ready) begin
                        r_state        <= S_IDLE;
                        r_result_valid <= 1'b0;
                        r_instr_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_instr_ready  <= 1'b1;
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef OP_SEQUENCER_FLAGS_EN
    logic r_flag_z;
    logic r_flag_n;
    logic r_flag_v;

    // Overflow only means something for ADD/SUB; logic ops clear V.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_v <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_flag_z <= (computedValue == '0);
            r_flag_n <= computedValue[width-1];
            r_flag_v <= overflow & r_add_sub;
        end
    end

    assign flag_z = r_flag_z;
    assign flag_n = r_flag_n;
    assign flag_v = r_flag_v;
`else
    logic w_unused_ovf;

    assign w_unused_ovf = overflow;
    assign flag_z       = 1'b0;
    assign flag_n       = 1'b0;
    assign flag_v       = 1'b0;
`endif

    assign instr_ready  = r_instr_ready;
    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign Ain          = r_a;
    assign Bin          = r_b;
    assign addSubVals   = r_add_sub;
    assign sub          = r_sub;
    assign andVals      = r_and;
    assign notBVal      = r_not;

endmodule
